// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one synchronous memory port between two requesters
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  localparam logic [2:0] LAT = 3'(MEM_LAT);
  state_t state, state_n;
  logic [2:0] cnt;
  logic gnt_b, grant, we_g, cap;
  assign gnt_b = b_req & (~a_req | ~owner);
  assign grant = (state == IDLE) & (a_req | b_req);
  assign we_g = gnt_b ? b_we : a_we;
  assign cap = (state == WAIT) & (cnt == 3'd1);
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state: one-cycle strobe, read wait of MEM_LAT cycles, one-cycle ack
  always_comb begin
    state_n = state;
    state_n = (state == IDLE)   ? ((a_req | b_req) ? ACCESS : IDLE)
            : (state == ACCESS) ? (mem_write ? DONE : WAIT)
            : (state == WAIT)   ? ((cnt == 3'd1) ? DONE : WAIT)
            : IDLE;
  end
  // grant latch, memory strobes, latency counter, read capture and acks
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      busy      <= 1'b0;
      owner     <= 1'b1;
      cnt       <= '0;
    end else begin
      mem_read  <= grant & ~we_g;
      mem_write <= grant & we_g;
      if (grant) begin
        owner     <= gnt_b;
        mem_addr  <= gnt_b ? b_addr : a_addr;
        mem_wdata <= gnt_b ? b_wdata : a_wdata;
      end
      cnt <= (state == ACCESS) ? LAT : (state == WAIT) ? cnt - 3'd1 : cnt;
      if (cap & ~owner) a_rdata <= mem_rdata;
      if (cap & owner) b_rdata <= mem_rdata;
      a_ack <= (state_n == DONE) & ~owner;
      b_ack <= (state_n == DONE) & owner;
      busy  <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven and scoreboard checks of mem_arbiter with MEM_LAT 1 and 3
module tb_mem_arbiter;
  localparam int MEM_LAT = 1;
  typedef struct {logic port; logic we; logic [15:0] addr; logic [15:0] wdata; logic [15:0] exp_rd;} vec_t;
  typedef struct {logic port; logic rd; logic [15:0] data;} exp_t;
  logic clock = 1'b0;
  logic reset, mem_clr;
  logic a_req, a_we, a_ack, b_req, b_we, b_ack;
  logic [15:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
  logic mem_read, mem_write, busy, owner;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic a3_req, a3_we, a3_ack, b3_ack, mem_read3, mem_write3, busy3, owner3;
  logic [15:0] a3_addr, a3_wdata, a3_rdata, b3_rdata, mem_addr3, mem_wdata3, mem_rdata3;
  logic [15:0] mem [256];
  logic [15:0] p3 [3];
  logic prev_rd, prev_wr;
  exp_t sb [$];
  vec_t vecs [10];
  logic [15:0] last_a, last_b;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(MEM_LAT)) u_dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(3)) u_dut3 (
    .clock(clock), .reset(reset),
    .a_req(a3_req), .a_we(a3_we), .a_addr(a3_addr), .a_wdata(a3_wdata), .a_ack(a3_ack), .a_rdata(a3_rdata),
    .b_req(1'b0), .b_we(1'b0), .b_addr(16'h0000), .b_wdata(16'h0000), .b_ack(b3_ack), .b_rdata(b3_rdata),
    .mem_read(mem_read3), .mem_write(mem_write3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3), .owner(owner3)
  );

  // single-cycle-latency memory; non-read cycles present garbage
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h10] <= 16'h1234;
    end else begin
      if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= mem_read ? mem[mem_addr[7:0]] : 16'hDEAD;
    end
  end

  // three-cycle-latency memory returning a function of the address
  always @(posedge clock) begin
    p3[0] <= mem_read3 ? (16'hC0DE ^ mem_addr3) : 16'hBAD0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata3 = p3[2];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // protocol monitor and scoreboard consumer
  always @(negedge clock) begin
    chk("strobe_excl", 32'(mem_read & mem_write), 32'd0);
    chk("strobe_1cyc", 32'((mem_read & prev_rd) | (mem_write & prev_wr)), 32'd0);
    prev_rd <= mem_read;
    prev_wr <= mem_write;
    if (a_ack || b_ack) begin
      chk("ack_excl", 32'(a_ack & b_ack), 32'd0);
      chk("ack_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_port", 32'(b_ack), 32'(e.port));
        if (e.rd) chk("ack_rdata", 32'(e.port ? b_rdata : a_rdata), 32'(e.data));
      end
    end
  end

  task automatic xact(input logic port, input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                      input logic [15:0] exp_rd, input bit drop_early);
    int lat;
    bit got;
    lat = we ? 2 : MEM_LAT + 2;
    if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
    else begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
    sb.push_back('{port, ~we, exp_rd});
    got = 0;
    for (int k = 1; k <= 12 && !got; k++) begin
      @(negedge clock);
      chk("mem_addr_hold", 32'(mem_addr), 32'(addr));
      if (we) chk("mem_wdata_hold", 32'(mem_wdata), 32'(wdata));
      chk("strobe", 32'({mem_read, mem_write}), k == 1 ? 32'({~we, we}) : 32'd0);
      if (k == 1) chk("owner", 32'(owner), 32'(port));
      if (a_ack || b_ack) begin
        got = 1;
        chk("latency", k, lat);
      end else begin
        if (drop_early) begin a_req = 0; b_req = 0; end
        a_addr = 16'($urandom); a_wdata = 16'($urandom); a_we = 1'($urandom);
        b_addr = 16'($urandom); b_wdata = 16'($urandom); b_we = 1'($urandom);
      end
    end
    chk("ack_timeout", 32'(got), 32'd1);
    a_req = 0;
    b_req = 0;
    if (!we) begin
      if (port) last_b = exp_rd;
      else last_a = exp_rd;
    end
    chk("a_rdata_keep", 32'(a_rdata), 32'(last_a));
    chk("b_rdata_keep", 32'(b_rdata), 32'(last_b));
    @(negedge clock);
  endtask

  task automatic do_reset();
    a_req = 0;
    b_req = 0;
    reset = 1;
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    last_a = 16'h0000;
    last_b = 16'h0000;
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gcyc [6];
    logic gown [6];
    logic [15:0] gaddr [6];
    vecs[0] = '{1'b1, 1'b1, 16'h0005, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b1, 16'h0020, 16'h1111, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1111};
    vecs[4] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234};
    vecs[5] = '{1'b0, 1'b1, 16'h00FF, 16'hFFFF, 16'h0000};
    vecs[6] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'hFFFF};
    vecs[7] = '{1'b1, 1'b1, 16'h0000, 16'h0001, 16'h0000};
    vecs[8] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0001};
    vecs[9] = '{1'b0, 1'b0, 16'h0077, 16'h0000, 16'h0000};
    reset = 1; mem_clr = 1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    a3_req = 0; a3_we = 0; a3_addr = 0; a3_wdata = 0;
    prev_rd = 0; prev_wr = 0;
    last_a = 0; last_b = 0;
    repeat (3) @(negedge clock);
    chk("reset_ctrl", 32'({mem_read, mem_write, a_ack, b_ack, busy, owner}), 32'(6'b000001));
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("reset_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    mem_clr = 0;
    reset = 0;
    @(negedge clock);
    // read of 0x0010 on A: strobe in T1 only, ack and data in T3
    a_req = 1; a_we = 0; a_addr = 16'h0010;
    sb.push_back('{1'b0, 1'b1, 16'h1234});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chk("t1_read", 32'(mem_read), 32'(k == 1));
      chk("t1_addr", 32'(mem_addr), 32'h0010);
      chk("t1_a_ack", 32'(a_ack), 32'(k == 3));
      chk("t1_b_ack", 32'(b_ack), 32'd0);
      chk("t1_busy", 32'(busy), 32'(k <= 3));
      if (k == 3) begin
        chk("t1_rdata", 32'(a_rdata), 32'h1234);
        a_req = 0;
      end
    end
    last_a = 16'h1234;
    // single-port transactions from the table
    for (int i = 0; i < 10; i++)
      xact(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b0);
    // requester abandons the read during ACCESS
    xact(1'b0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b1);
    // tie after reset: strict A,B alternation, 3 cycles apart
    do_reset();
    a_we = 1; b_we = 1;
    a_addr = 16'h0030; a_wdata = 16'hAAAA;
    b_addr = 16'h0031; b_wdata = 16'hBBBB;
    for (int i = 0; i < 6; i++) sb.push_back('{1'(i % 2), 1'b0, 16'h0000});
    a_req = 1; b_req = 1;
    n = 0;
    for (int k = 0; k < 60 && n < 6; k++) begin
      @(negedge clock);
      if (mem_write) begin
        gcyc[n] = cyc;
        gown[n] = owner;
        gaddr[n] = mem_addr;
        n++;
        if (n == 6) begin a_req = 0; b_req = 0; end
      end
    end
    chk("tie_grants", n, 6);
    for (int i = 0; i < n; i++) begin
      chk("tie_owner", 32'(gown[i]), 32'(i % 2));
      chk("tie_addr", 32'(gaddr[i]), (i % 2) ? 32'h0031 : 32'h0030);
      if (i > 0) chk("tie_spacing", gcyc[i] - gcyc[i-1], 3);
    end
    repeat (4) @(negedge clock);
    chk("tie_sb_empty", sb.size(), 0);
    // reset during WAIT: immediate clear, no ack, then tie goes to A
    a_req = 1; a_we = 0; a_addr = 16'h0010;
    @(negedge clock);
    chk("rst_strobe", 32'(mem_read), 32'd1);
    @(negedge clock);
    a_req = 0;
    reset = 1;
    #1;
    chk("rst_async", 32'({mem_read, mem_write, a_ack, b_ack, busy, owner}), 32'(6'b000001));
    chk("rst_async_addr", 32'(mem_addr), 32'd0);
    chk("rst_async_rdata", 32'(a_rdata), 32'd0);
    last_a = 0; last_b = 0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_no_ack", 32'({a_ack, b_ack}), 32'd0);
    reset = 0;
    a_req = 1; b_req = 1; a_we = 0; b_we = 0;
    a_addr = 16'h0005; b_addr = 16'h0010;
    sb.push_back('{1'b0, 1'b1, 16'hBEEF});
    @(negedge clock);
    chk("rst_tie_owner", 32'(owner), 32'd0);
    chk("rst_tie_addr", 32'(mem_addr), 32'h0005);
    a_req = 0; b_req = 0;
    repeat (4) @(negedge clock);
    chk("rst_sb_empty", sb.size(), 0);
    chk("rst_tie_rdata", 32'(a_rdata), 32'hBEEF);
    // MEM_LAT = 3 instance: early garbage ignored, ack 5 cycles after sampling
    a3_req = 1; a3_we = 0; a3_addr = 16'h0042;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      chk("l3_read", 32'(mem_read3), 32'(k == 1));
      chk("l3_addr", 32'(mem_addr3), 32'h0042);
      chk("l3_a_ack", 32'(a3_ack), 32'(k == 5));
      chk("l3_b_ack", 32'(b3_ack), 32'd0);
      chk("l3_busy", 32'(busy3), 32'(k <= 5));
      if (k == 5) begin
        chk("l3_rdata", 32'(a3_rdata), 32'(16'hC0DE ^ 16'h0042));
        a3_req = 0;
      end
      a3_addr = 16'($urandom);
      a3_wdata = 16'($urandom);
    end
    chk("l3_rdata_hold", 32'(a3_rdata), 32'(16'hC0DE ^ 16'h0042));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
